neighbor_gates_pipe: RTL and testbench

Parametrised, pipelined neighbour-bit analyser. It accepts a stream of WIDTH-bit vectors over a valid/ready handshake. For each vector it produces the pairwise AND, OR and XOR of adjacent bits (XOR optionally wrapping around), the number of adjacent-bit differences, and the bits that changed since the previous accepted vector. It also keeps a saturating running total of differences. It sits between a vector source and any downstream consumer that applies backpressure.

---
 rtl/neighbor_gates_pipe_if.sv | 46 ++++
 rtl/neighbor_gates_pipe.sv | 111 +++++++++++
 tb/tb_neighbor_gates_pipe.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/neighbor_gates_pipe_if.sv
// rtl/neighbor_gates_pipe_if.sv - stream and status bundle for neighbor_gates_pipe
//
// Purpose: groups the input stream, output stream, clear strobe and result
// fields of neighbor_gates_pipe into one interface.
//   master : vector source / consumer side (drives clr, in_valid, in_data, out_ready)
//   slave  : the analyser (drives in_ready, out_valid and all result fields)
// Signals:
//   clr            sync clear of running total and history
//   in_valid/in_ready/in_data         input beat handshake
//   out_valid/out_ready               output beat handshake
//   out_both, out_any   [WIDTH-2:0]   adjacent AND / OR
//   out_different       [WIDTH-1:0]   adjacent XOR (top bit optionally wraps)
//   diff_count          [DC_W-1:0]    popcount of out_different
//   out_changed         [WIDTH-1:0]   vector XOR previous accepted vector
//   total_count         [CNT_W-1:0]   saturating sum of transferred diff_count
interface neighbor_gates_pipe_if #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 16
);
   localparam int DC_W = $clog2(WIDTH + 1);

   logic             clr;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-2:0] out_both;
   logic [WIDTH-2:0] out_any;
   logic [WIDTH-1:0] out_different;
   logic [DC_W-1:0]  diff_count;
   logic [WIDTH-1:0] out_changed;
   logic [CNT_W-1:0] total_count;

   modport master (
      output clr, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_both, out_any, out_different,
             diff_count, out_changed, total_count
   );

   modport slave (
      input  clr, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_both, out_any, out_different,
             diff_count, out_changed, total_count
   );
endinterface

// File: rtl/neighbor_gates_pipe.sv
// rtl/neighbor_gates_pipe.sv - two-stage pipelined neighbour-bit analyser
//
// Purpose: for each accepted WIDTH-bit vector, produces adjacent-bit AND, OR
// and XOR, the count of adjacent differences, the bits changed since the
// previous accepted vector, and a saturating running total of differences.
// Ports:
//   clk      rising-edge clock
//   aresetn  asynchronous active-low reset
//   bus      neighbor_gates_pipe_if.slave (stream handshakes, clr, results)
// Parameters:
//   WIDTH (>=2) vector width, WRAP selects wrap-around on the top XOR bit,
//   CNT_W (>=1) width of total_count.
module neighbor_gates_pipe #(
   parameter int WIDTH = 4,
   parameter bit WRAP  = 1'b1,
   parameter int CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  aresetn,
   neighbor_gates_pipe_if.slave  bus
);
   localparam int DC_W  = $clog2(WIDTH + 1);
   // Wide enough that neither operand nor the carry is lost, even when
   // diff_count is wider than total_count.
   localparam int SUM_W = ((CNT_W > DC_W) ? CNT_W : DC_W) + 1;
   localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

   logic             s1_valid;
   logic [WIDTH-1:0] s1_data;
   logic [WIDTH-1:0] s1_changed;
   logic [WIDTH-1:0] prev;

   logic             accept;
   logic             s2_load;
   logic             xfer;

   logic [WIDTH-2:0] both_c;
   logic [WIDTH-2:0] any_c;
   logic [WIDTH-1:0] diff_c;
   logic [DC_W-1:0]  cnt_c;
   logic [SUM_W-1:0] sum_c;

   assign s2_load     = s1_valid && (!bus.out_valid || bus.out_ready);
   assign bus.in_ready = !s1_valid || s2_load;
   assign accept      = bus.in_valid && bus.in_ready;
   assign xfer        = bus.out_valid && bus.out_ready;

   always_comb begin
      both_c = '0;
      any_c  = '0;
      diff_c = '0;
      cnt_c  = '0;
      for (int i = 0; i < WIDTH - 1; i++) begin
         both_c[i] = s1_data[i] & s1_data[i+1];
         any_c[i]  = s1_data[i] | s1_data[i+1];
         diff_c[i] = s1_data[i] ^ s1_data[i+1];
      end
      diff_c[WIDTH-1] = WRAP ? (s1_data[WIDTH-1] ^ s1_data[0]) : 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_c = cnt_c + DC_W'(diff_c[i]);
      end
   end

   assign sum_c = SUM_W'(bus.total_count) + SUM_W'(bus.diff_count);

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         s1_valid          <= 1'b0;
         s1_data           <= '0;
         s1_changed        <= '0;
         prev              <= '0;
         bus.out_valid     <= 1'b0;
         bus.out_both      <= '0;
         bus.out_any       <= '0;
         bus.out_different <= '0;
         bus.diff_count    <= '0;
         bus.out_changed   <= '0;
         bus.total_count   <= '0;
      end else begin
         // Stage 1: capture vector and its delta against the old history.
         if (accept) begin
            s1_data    <= bus.in_data;
            s1_changed <= bus.in_data ^ prev;
         end
         if (accept)       s1_valid <= 1'b1;
         else if (s2_load) s1_valid <= 1'b0;

         // History: clear takes priority over an accepted vector, but the
         // accepted beat above still used the pre-clear value.
         if (bus.clr)     prev <= '0;
         else if (accept) prev <= bus.in_data;

         // Stage 2: registered results; held while the consumer stalls.
         if (s2_load) begin
            bus.out_both      <= both_c;
            bus.out_any       <= any_c;
            bus.out_different <= diff_c;
            bus.diff_count    <= cnt_c;
            bus.out_changed   <= s1_changed;
         end
         if (s2_load)   bus.out_valid <= 1'b1;
         else if (xfer) bus.out_valid <= 1'b0;

         // Running total: clear wins over a coincident transfer.
         if (bus.clr)
            bus.total_count <= '0;
         else if (xfer)
            bus.total_count <= (sum_c > CNT_MAX) ? {CNT_W{1'b1}} : sum_c[CNT_W-1:0];
      end
   end
endmodule

// File: tb/tb_neighbor_gates_pipe.sv
// tb/tb_neighbor_gates_pipe.sv - directed self-checking bench for neighbor_gates_pipe
module tb_neighbor_gates_pipe;
   logic clk = 1'b0;
   logic aresetn = 1'b0;
   int   checks = 0;
   int   failures = 0;
   int   sat_exp [6] = '{4, 8, 12, 15, 15, 15};

   always #5 clk = ~clk;

   neighbor_gates_pipe_if #(.WIDTH(4), .CNT_W(16)) ia ();
   neighbor_gates_pipe_if #(.WIDTH(4), .CNT_W(16)) ib ();
   neighbor_gates_pipe_if #(.WIDTH(4), .CNT_W(4))  ic ();

   neighbor_gates_pipe #(.WIDTH(4), .WRAP(1'b1), .CNT_W(16)) dut_a (.clk(clk), .aresetn(aresetn), .bus(ia));
   neighbor_gates_pipe #(.WIDTH(4), .WRAP(1'b0), .CNT_W(16)) dut_b (.clk(clk), .aresetn(aresetn), .bus(ib));
   neighbor_gates_pipe #(.WIDTH(4), .WRAP(1'b1), .CNT_W(4))  dut_c (.clk(clk), .aresetn(aresetn), .bus(ic));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_a(input string tag, input logic [2:0] both, input logic [2:0] any,
                        input logic [3:0] diff, input int dc, input logic [3:0] chg);
      chk({tag, "_valid"}, ia.out_valid, 1);
      chk({tag, "_both"},  ia.out_both, both);
      chk({tag, "_any"},   ia.out_any, any);
      chk({tag, "_diff"},  ia.out_different, diff);
      chk({tag, "_dc"},    ia.diff_count, dc);
      chk({tag, "_chg"},   ia.out_changed, chg);
   endtask

   initial begin
      ia.clr = 0; ia.in_valid = 0; ia.in_data = '0; ia.out_ready = 0;
      ib.clr = 0; ib.in_valid = 0; ib.in_data = '0; ib.out_ready = 0;
      ic.clr = 0; ic.in_valid = 0; ic.in_data = '0; ic.out_ready = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      aresetn = 1'b1;
      tick();

      // Reset state
      chk("rst_in_ready", ia.in_ready, 1);
      chk("rst_out_valid", ia.out_valid, 0);
      chk("rst_diff", ia.out_different, 0);
      chk("rst_chg", ia.out_changed, 0);
      chk("rst_dc", ia.diff_count, 0);
      chk("rst_total", ia.total_count, 0);

      // Smoke stream 0011, 0110, 1100, 1111 at full throughput
      ia.out_ready = 1;
      ia.in_valid = 1; ia.in_data = 4'b0011; tick();
      chk("lat_not_yet", ia.out_valid, 0);
      ia.in_data = 4'b0110; tick();
      chk_a("b0", 3'b001, 3'b011, 4'b1010, 2, 4'b0011);
      chk("b0_total", ia.total_count, 0);
      ia.in_data = 4'b1100; tick();
      chk_a("b1", 3'b010, 3'b111, 4'b0101, 2, 4'b0101);
      chk("b1_total", ia.total_count, 2);
      ia.in_data = 4'b1111; tick();
      chk_a("b2", 3'b100, 3'b110, 4'b1010, 2, 4'b1010);
      chk("b2_total", ia.total_count, 4);
      ia.in_valid = 0; tick();
      chk_a("b3", 3'b111, 3'b111, 4'b0000, 0, 4'b0011);
      tick();
      chk("smoke_drain_valid", ia.out_valid, 0);
      chk("smoke_total", ia.total_count, 6);

      // WRAP=0 on 0011
      ib.out_ready = 1; ib.in_valid = 1; ib.in_data = 4'b0011; tick();
      ib.in_valid = 0; tick();
      chk("nowrap_valid", ib.out_valid, 1);
      chk("nowrap_diff", ib.out_different, 4'b0010);
      chk("nowrap_dc", ib.diff_count, 1);

      // Saturation with CNT_W=4 on repeated 0101
      ic.out_ready = 1; ic.in_valid = 1; ic.in_data = 4'b0101; tick(); tick();
      chk("sat_diff", ic.out_different, 4'b1111);
      chk("sat_dc", ic.diff_count, 4);
      chk("sat_total0", ic.total_count, 0);
      for (int k = 0; k < 6; k++) begin
         if (k == 3) ic.in_valid = 0;
         tick();
         chk($sformatf("sat_total%0d", k + 1), ic.total_count, sat_exp[k]);
      end

      // Backpressure: prev=1111, beats A=0001 B=0010 C=0100
      ia.out_ready = 0; ia.in_valid = 1; ia.in_data = 4'b0001; #1;
      chk("bp_ready0", ia.in_ready, 1);
      tick();
      chk("bp_ready1", ia.in_ready, 1);
      ia.in_data = 4'b0010; tick();
      ia.in_data = 4'b0100; #1;
      chk("bp_ready2", ia.in_ready, 0);
      for (int k = 0; k < 4; k++) begin
         chk_a($sformatf("bp_hold%0d", k), 3'b000, 3'b001, 4'b1001, 2, 4'b1110);
         chk($sformatf("bp_stall_ready%0d", k), ia.in_ready, 0);
         chk($sformatf("bp_total%0d", k), ia.total_count, 6);
         tick();
      end
      ia.out_ready = 1; #1;
      chk("bp_release_ready", ia.in_ready, 1);
      tick();
      ia.in_valid = 0;
      chk_a("bp_b", 3'b000, 3'b011, 4'b0011, 2, 4'b0011);
      chk("bp_total_a", ia.total_count, 8);
      tick();
      chk_a("bp_c", 3'b000, 3'b110, 4'b0110, 2, 4'b0110);
      chk("bp_total_b", ia.total_count, 10);
      tick();
      chk("bp_drained", ia.out_valid, 0);
      chk("bp_total_c", ia.total_count, 12);

      // clr coincident with transfer of a count-2 beat (prev=0100)
      ia.in_valid = 1; ia.in_data = 4'b0011; tick();
      ia.in_valid = 0; tick();
      chk_a("clr_beat", 3'b001, 3'b011, 4'b1010, 2, 4'b0111);
      ia.clr = 1; tick();
      ia.clr = 0;
      chk("clr_total", ia.total_count, 0);
      chk("clr_valid", ia.out_valid, 0);
      ia.in_valid = 1; ia.in_data = 4'b1000; tick();
      ia.in_valid = 0; tick();
      chk_a("clr_next", 3'b000, 3'b100, 4'b1100, 2, 4'b1000);
      chk("clr_next_total", ia.total_count, 0);
      tick();
      chk("clr_after_total", ia.total_count, 2);

      // Asynchronous reset with both stages full
      ia.out_ready = 0; ia.in_valid = 1; ia.in_data = 4'b0101; tick();
      ia.in_data = 4'b0110; tick();
      chk("full_valid", ia.out_valid, 1);
      chk("full_ready", ia.in_ready, 0);
      #1 aresetn = 1'b0;
      #1;
      chk("arst_valid", ia.out_valid, 0);
      chk("arst_total", ia.total_count, 0);
      chk("arst_chg", ia.out_changed, 0);
      ia.in_valid = 0; ia.out_ready = 1;
      tick();
      @(negedge clk);
      aresetn = 1'b1;
      tick();
      chk("post_rst_valid", ia.out_valid, 0);
      ia.in_valid = 1; ia.in_data = 4'b0011; tick();
      ia.in_valid = 0; tick();
      chk_a("post_rst", 3'b001, 3'b011, 4'b1010, 2, 4'b0011);
      tick();
      chk("post_rst_total", ia.total_count, 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
